mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Downstream consumer of the 4x4 pipelined multiplier.
- Shadows the multiplier's fixed 3-cycle latency with a valid/last delay line, then accumulates the 8-bit products into a dot-product sum.
- Each completed sum is queued in a 2-entry result buffer and released through a valid/ready handshake.
- Drives in_ready back to the operand source, so no completed result is ever lost.

Parameters:
- ACC_W, 16, accumulator and out_sum width (must be >= 8).
- CNT_W, 8, width of the per-group product counter.
- MULT_LAT, 3, multiplier latency in clk cycles; must equal the multiplier's register depth.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair x,y is presented to the multiplier this cycle.
- in_last  in  1  qualifies in_valid: this pair closes the current group.
- in_ready  out  1  source may issue an operand pair this cycle.
- z  in  8  product from the multiplier, valid MULT_LAT cycles after issue.
- out_valid  out  1  result buffer head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_sum  out  ACC_W  accumulated group sum at buffer head.
- out_count  out  CNT_W  number of products in the group at buffer head.
- out_ovf  out  1  group overflowed (wrapped or saturated).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - delay line, accumulator, counter and buffer are all cleared.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 on the following cycle.
  - A reset mid-group discards the partial sum and all in-flight products.
- Issue: a pair is issued when in_valid && in_ready. in_valid while in_ready=0 is ignored and nothing enters the delay line.
- Delay line: MULT_LAT stages of {v,last}, shifting every cycle with no stall. Stage MULT_LAT-1 output (dv, dlast) aligns with z.
- Accumulation, when dv=1:
  - acc <= acc + zero-extended z
  - cnt <= cnt + 1
  - ovf <= ovf | carry-out of ACC_W
  - cnt wraps at 2^CNT_W silently.
- Group close, when dv && dlast:
  - {acc+z, cnt+1, ovf|carry} is pushed into the result buffer.
  - acc, cnt and ovf are cleared in the same cycle, so the next dv starts a fresh group with no bubble.
- Accumulator FSM:
  - EMPTY: acc=0. dv moves to ACTIVE, or stays in EMPTY if dlast is also set (single-product group).
  - ACTIVE: dv&&dlast returns to EMPTY.
  - dv=0 holds the current state.
- Result buffer: 2-entry FIFO; head drives out_*.
  - out_valid = occupancy != 0.
  - Pop on out_valid && out_ready. A push and a pop in the same cycle keeps occupancy unchanged.
  - Outputs are held stable while out_valid && !out_ready.
- Flow control:
  - inflight = number of delay-line stages holding v&&last.
  - in_ready = (occupancy + inflight) < 2, combinational from registered state.
  - This guarantees a push never finds the buffer full. A push when full is a design error; a simulation assertion fires.
  - Non-last pairs are also blocked while in_ready=0, which keeps the logic simple.
- Latency: last pair issued at cycle T → out_valid=1 at T+MULT_LAT+1.

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the group; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf=1 is sticky for the group.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package mac_pkg:
  - MULT_LAT, PROD_W=8, and default ACC_W/CNT_W constants.
  - A result struct typedef {sum, count, ovf} used by the FIFO entries.
- One natural sub-module: valid_delay_line, a parameterised MULT_LAT-deep shift of {v,last} that also outputs the inflight-last count.

Test Plan:
- Reset then a single group: x,y pairs (3,5),(15,15),(2,7) with last on the third → out_sum=254, out_count=3, out_ovf=0, out_valid exactly 4 cycles after the last issue.
- Back-to-back groups with no idle cycle, (1,1)last then (4,4)last, out_ready=1 → two results 1 then 16 on consecutive cycles; no cross-group leakage.
- Backpressure: out_ready=0, issue three single-product last groups → in_ready falls after the second issue, the third is held until a pop; all three results emerge in order after out_ready=1.
- Overflow with ACC_W=9: issue (15,15),(15,15),(15,15) last →
  - out_sum=163, out_ovf=1 without MAC_ACC_SATURATE_EN.
  - out_sum=511, out_ovf=1 with it.
- Reset mid-group: issue (2,2),(3,3), then assert rst_n=0 for one cycle → no out_valid. Next group (1,2)last → out_sum=2, out_count=1.
- Handshake stability: hold out_ready=0 for 10 cycles with a valid head → out_sum, out_count and out_ovf are unchanged; a simultaneous push and pop keeps occupancy at 1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC accumulator slice.
package mac_pkg;

    localparam int unsigned PROD_W       = 8;
    localparam int unsigned MULT_LAT_DEF = 3;
    localparam int unsigned ACC_W_DEF    = 16;
    localparam int unsigned CNT_W_DEF    = 8;

    // FIFO entries are sized for the widest supported build; narrower builds
    // zero-fill the upper bits.
    localparam int unsigned ACC_W_MAX = 32;
    localparam int unsigned CNT_W_MAX = 16;

    typedef struct packed {
        logic [ACC_W_MAX-1:0] sum;
        logic [CNT_W_MAX-1:0] count;
        logic                 ovf;
    } result_t;

    typedef enum logic [0:0] {
        StEmpty,
        StActive
    } acc_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register of {v,last} that shadows the multiplier pipeline and reports
// how many group-closing products are still in flight.
module valid_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_v,
    input  logic             issue_last,
    output logic             dv,
    output logic             dlast,
    output logic [CNT_W-1:0] inflight
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] last_q;

    // Shift every cycle; last is stored already qualified by v.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            last_q <= '0;
        end else begin
            v_q[0]    <= issue_v;
            last_q[0] <= issue_v && issue_last;
            for (int i = 1; i < int'(DEPTH); i++) begin
                v_q[i]    <= v_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign dv    = v_q[DEPTH-1];
    assign dlast = last_q[DEPTH-1];

    // Count of closing products in any stage, including the one aligned with z.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            inflight = inflight + CNT_W'(v_q[i] & last_q[i]);
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind the pipelined 4x4 multiplier. Completed group
// sums go through a 2-entry result buffer with a valid/ready handshake.
// Optional build macro MAC_ACC_SATURATE_EN: clamp the sum on overflow instead
// of wrapping. Supports ACC_W in [8, 32] and CNT_W up to 16.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [PROD_W-1:0] z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int unsigned INFL_W = $clog2(MULT_LAT + 1);
    localparam int unsigned PEND_W = INFL_W + 2;

    logic              issue;
    logic              dv;
    logic              dlast;
    logic [INFL_W-1:0] inflight;

    assign issue = in_valid && in_ready;

    valid_delay_line #(
        .DEPTH (MULT_LAT),
        .CNT_W (INFL_W)
    ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_v    (issue),
        .issue_last (in_last),
        .dv         (dv),
        .dlast      (dlast),
        .inflight   (inflight)
    );

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_base, acc_sum;
    logic [ACC_W:0]   acc_ext;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
    logic             ovf_q, ovf_d, ovf_sum;
    logic             push;
    logic             pop;
    result_t          push_entry;

    // Accumulate the aligned product; close the group and restart on dlast.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        acc_base = (state_q == StEmpty) ? '0 : acc_q;
        acc_ext  = {1'b0, acc_base} + (ACC_W + 1)'(z);
        ovf_sum  = ovf_q | acc_ext[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
        // Once saturated, the sum stays pinned for the rest of the group.
        acc_sum  = ovf_sum ? '1 : acc_ext[ACC_W-1:0];
`else
        acc_sum  = acc_ext[ACC_W-1:0];
`endif
        cnt_sum  = cnt_q + CNT_W'(1);
        push     = dv && dlast;

        unique case (state_q)
            StEmpty:  if (dv && !dlast) state_d = StActive;
            StActive: if (dv && dlast)  state_d = StEmpty;
        endcase

        if (dv) begin
            if (dlast) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_sum;
                ovf_d = ovf_sum;
            end
        end

        push_entry                  = '0;
        push_entry.sum[ACC_W-1:0]   = acc_sum;
        push_entry.count[CNT_W-1:0] = cnt_sum;
        push_entry.ovf              = ovf_sum;
    end

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    result_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;
    result_t    head;

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;

    // Two-entry result FIFO; head entry drives the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign out_sum   = head.sum[ACC_W-1:0];
    assign out_count = head.count[CNT_W-1:0];
    assign out_ovf   = head.ovf;

    logic unused_head;
    assign unused_head = ^head;

    // Reserve a buffer slot for every closing product already issued.
    logic [PEND_W-1:0] pending;

    always_comb begin
        pending  = PEND_W'(occ_q) + PEND_W'(inflight);
        in_ready = (pending < PEND_W'(2));
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) push |-> (occ_q != 2'd2)
    ) else $error("result buffer push while full");

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (16-bit and 9-bit sums) share
// stimulus; a behavioural model tracks closed groups in a queue.
module tb_mac_accumulator;
    import mac_pkg::*;

    localparam int unsigned LAT = MULT_LAT_DEF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [7:0] z;
    logic [7:0] mpipe [LAT];

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] sum_a;
    logic [7:0]  cnt_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [8:0]  sum_b;
    logic [7:0]  cnt_b;

    always #5 clk = ~clk;

    // Stand-in for the pipelined multiplier.
    always @(posedge clk) begin
        mpipe[0] <= 8'(x) * 8'(y);
        for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
    end
    assign z = mpipe[LAT-1];

    mac_accumulator #(.ACC_W(16), .CNT_W(8), .MULT_LAT(LAT)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready_a),
        .z         (z),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_sum   (sum_a),
        .out_count (cnt_a),
        .out_ovf   (ovf_a)
    );

    mac_accumulator #(.ACC_W(9), .CNT_W(8), .MULT_LAT(LAT)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready_b),
        .z         (z),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_sum   (sum_b),
        .out_count (cnt_b),
        .out_ovf   (ovf_b)
    );

    typedef struct {
        longint sum;
        int     count;
        int     rdy;
    } exp_t;

    exp_t   expq[$];
    longint g_sum = 0;
    int     g_cnt = 0;
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint exp_sum(input longint full, input int w);
        longint lim;
        lim = longint'(1) << w;
        if (full < lim) return full;
`ifdef MAC_ACC_SATURATE_EN
        return lim - 1;
`else
        return full % lim;
`endif
    endfunction

    // One clock: check outputs, advance the model, cross the edge.
    task automatic cycle(output bit issued);
        bit exp_ready;
        bit exp_valid;
        exp_t e;
        exp_ready = (expq.size() < 2);
        exp_valid = (expq.size() != 0) && (expq[0].rdy <= cyc);
        chk("in_ready_a", in_ready_a, exp_ready);
        chk("in_ready_b", in_ready_b, exp_ready);
        chk("out_valid_a", out_valid_a, exp_valid);
        chk("out_valid_b", out_valid_b, exp_valid);
        if (exp_valid) begin
            chk("sum_a", sum_a, exp_sum(expq[0].sum, 16));
            chk("count_a", cnt_a, expq[0].count % 256);
            chk("ovf_a", ovf_a, (expq[0].sum >= 65536) ? 1 : 0);
            chk("sum_b", sum_b, exp_sum(expq[0].sum, 9));
            chk("count_b", cnt_b, expq[0].count % 256);
            chk("ovf_b", ovf_b, (expq[0].sum >= 512) ? 1 : 0);
        end
        if (exp_valid && out_ready) void'(expq.pop_front());
        issued = in_valid && exp_ready;
        if (issued) begin
            g_sum += longint'(int'(x) * int'(y));
            g_cnt++;
            if (in_last) begin
                e.sum   = g_sum;
                e.count = g_cnt;
                e.rdy   = cyc + int'(LAT) + 1;
                expq.push_back(e);
                g_sum = 0;
                g_cnt = 0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit iss;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) cycle(iss);
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input bit last);
        bit iss;
        int n;
        n = 0;
        x = a;
        y = b;
        in_last = last;
        in_valid = 1'b1;
        do begin
            cycle(iss);
            n++;
        end while (!iss && n < 50);
        chk("send_issued", iss, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        expq.delete();
        g_sum = 0;
        g_cnt = 0;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_sum_a", sum_a, 0);
        chk("rst_count_a", cnt_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_sum_b", sum_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit iss;

        do_reset();

        // Single group: 15 + 225 + 14 = 254, valid 4 cycles after last issue.
        out_ready = 1'b1;
        send(4'd3, 4'd5, 1'b0);
        send(4'd15, 4'd15, 1'b0);
        send(4'd2, 4'd7, 1'b1);
        idle(6);

        // Back-to-back single-product groups.
        send(4'd1, 4'd1, 1'b1);
        send(4'd4, 4'd4, 1'b1);
        idle(6);

        // Backpressure: third group held until a pop frees a slot.
        out_ready = 1'b0;
        send(4'd1, 4'd3, 1'b1);
        send(4'd2, 4'd3, 1'b1);
        x = 4'd3;
        y = 4'd3;
        in_last = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            cycle(iss);
            chk("held_third", iss, 0);
        end
        out_ready = 1'b1;
        send(4'd3, 4'd3, 1'b1);
        idle(8);

        // Overflow: 675 wraps to 163 (or clamps to 511) at 9 bits.
        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b1);
        idle(6);

        // Reset mid-group discards the partial sum and in-flight products.
        send(4'd2, 4'd2, 1'b0);
        send(4'd3, 4'd3, 1'b0);
        do_reset();
        idle(6);
        send(4'd1, 4'd2, 1'b1);
        idle(6);

        // Head held stable under backpressure, then a same-cycle push/pop.
        out_ready = 1'b0;
        send(4'd5, 4'd6, 1'b1);
        idle(14);
        send(4'd7, 4'd7, 1'b1);
        idle(2);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(4);
        out_ready = 1'b1;
        idle(3);

        // Random traffic.
        repeat (400) begin
            in_valid  = ($urandom % 4) != 0;
            in_last   = ($urandom % 3) == 0;
            x         = 4'($urandom);
            y         = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            cycle(iss);
        end
        out_ready = 1'b1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
